// File: rtl/efx_fifo_pkg.sv
// Shared limits and elaboration helpers for the efx_fifo_sync synchronous FIFO model.
package efx_fifo_pkg;

    localparam int DATA_WIDTH_MIN = 1;
    localparam int DATA_WIDTH_MAX = 40;
    localparam int ADDR_WIDTH_MIN = 2;
    localparam int ADDR_WIDTH_MAX = 12;

    typedef enum logic {
        LVL_ALMOST_FULL  = 1'b0,
        LVL_ALMOST_EMPTY = 1'b1
    } almost_kind_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        clog2 = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v != 0) begin
            v = v >> 1;
            clog2 = clog2 + 1;
        end
    endfunction

    // Almost-full sits two words below full, almost-empty two words above empty.
    function automatic int unsigned default_almost_level(input int unsigned addr_width,
                                                         input almost_kind_e kind);
        if (kind == LVL_ALMOST_FULL) begin
            default_almost_level = (32'd1 << addr_width) - 2;
        end else begin
            default_almost_level = 2;
        end
    endfunction

endpackage

// File: rtl/efx_fifo_mem.sv
// Simple dual-port DEPTH x DATA_WIDTH storage with a synchronous read port and optional output register.
module efx_fifo_mem
    import efx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 20,
    parameter int DEPTH      = 256,
    parameter bit OUTPUT_REG = 1'b0,
    localparam int AW        = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    // Storage is deliberately not reset so it maps onto block RAM.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d  = rd_en ? mem_q[rd_addr] : rd_data_q;
        rd_valid_d = rd_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    if (OUTPUT_REG) begin : g_out_reg
        logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
        logic                  out_valid_q, out_valid_d;

        always_comb begin
            out_data_d  = rd_valid_q ? rd_data_q : out_data_q;
            out_valid_d = rd_valid_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_data_q  <= '0;
                out_valid_q <= 1'b0;
            end else begin
                out_data_q  <= out_data_d;
                out_valid_q <= out_valid_d;
            end
        end

        assign rd_data  = out_data_q;
        assign rd_valid = out_valid_q;
    end else begin : g_no_out_reg
        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

endmodule

// File: rtl/efx_fifo_sync.sv
// Depth/width-configurable synchronous FIFO: pointers, occupancy, status flags and
// polarity handling around the efx_fifo_mem block-RAM core.
module efx_fifo_sync
    import efx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH         = 20,
    parameter int ADDR_WIDTH         = 8,
    parameter bit OUTPUT_REG         = 1'b0,
    parameter bit WE_POLARITY        = 1'b1,
    parameter bit RE_POLARITY        = 1'b1,
    parameter int ALMOST_FULL_LEVEL  = int'(default_almost_level(ADDR_WIDTH, LVL_ALMOST_FULL)),
    parameter int ALMOST_EMPTY_LEVEL = int'(default_almost_level(ADDR_WIDTH, LVL_ALMOST_EMPTY))
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  WE,
    input  logic                  RE,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  RVALID,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int            DEPTH     = 1 << ADDR_WIDTH;
    localparam int            CW        = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL    = CW'(ALMOST_FULL_LEVEL);
    localparam logic [CW-1:0] AE_LVL    = CW'(ALMOST_EMPTY_LEVEL);

    if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_bad_data_width
        $error("efx_fifo_sync: DATA_WIDTH out of range");
    end
    if (ADDR_WIDTH < ADDR_WIDTH_MIN || ADDR_WIDTH > ADDR_WIDTH_MAX) begin : g_bad_addr_width
        $error("efx_fifo_sync: ADDR_WIDTH out of range");
    end
    if (ALMOST_FULL_LEVEL > DEPTH || ALMOST_EMPTY_LEVEL >= DEPTH) begin : g_bad_levels
        $error("efx_fifo_sync: almost level outside FIFO depth");
    end

    logic                  we_act, re_act, wr_ok, rd_ok;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d, empty_q, empty_d;
    logic                  afull_q, afull_d, aempty_q, aempty_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;

    // Request/ready contract: WE is a write request and !FULL its ready; RE is a read
    // request and !EMPTY its ready. A word moves only on an edge where request and
    // ready (registered flag) are both high; a request without ready is dropped, never held.
    always_comb begin
        we_act = (WE == WE_POLARITY);
        re_act = (RE == RE_POLARITY);
        wr_ok  = we_act && !full_q;
        rd_ok  = re_act && !empty_q;

        wr_ptr_d = wr_ok ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;

        count_d = count_q;
        if (wr_ok && !rd_ok) begin
            count_d = count_q + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CW'(1);
        end

        full_d   = (count_d == DEPTH_CNT);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= AF_LVL);
        aempty_d = (count_d <= AE_LVL);

        // A dropped write loses data; a read on empty paired with a write only waits
        // for that word, so it is not treated as an underflow.
        ovf_d = ovf_q | (we_act && full_q);
        unf_d = unf_q | (re_act && empty_q && !we_act);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    efx_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .OUTPUT_REG (OUTPUT_REG)
    ) u_mem (
        .clk      (CLK),
        .rst_n    (RST_N),
        .wr_en    (wr_ok),
        .wr_addr  (wr_ptr_q),
        .wr_data  (WDATA),
        .rd_en    (rd_ok),
        .rd_addr  (rd_ptr_q),
        .rd_data  (RDATA),
        .rd_valid (RVALID)
    );

    assign FULL         = full_q;
    assign EMPTY        = empty_q;
    assign ALMOST_FULL  = afull_q;
    assign ALMOST_EMPTY = aempty_q;
    assign COUNT        = count_q;
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = unf_q;

endmodule

// File: tb/tb_efx_fifo_sync.sv
// Directed bench for efx_fifo_sync: a default 256-deep instance and a 16-deep
// instance with output register and active-low request inputs.
module tb_efx_fifo_sync;

    localparam int DW = 20;

    logic          clk, rst_n;

    logic [DW-1:0] a_wdata, a_rdata;
    logic          a_we, a_re, a_rvalid, a_full, a_empty, a_afull, a_aempty, a_ovf, a_unf;
    logic [8:0]    a_count;

    logic [DW-1:0] b_wdata, b_rdata;
    logic          b_we, b_re, b_rvalid, b_full, b_empty, b_afull, b_aempty, b_ovf, b_unf;
    logic [4:0]    b_count;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_q[$];

    efx_fifo_sync #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (8)
    ) dut_a (
        .CLK (clk), .RST_N (rst_n), .WDATA (a_wdata), .WE (a_we), .RE (a_re),
        .RDATA (a_rdata), .RVALID (a_rvalid), .FULL (a_full), .EMPTY (a_empty),
        .ALMOST_FULL (a_afull), .ALMOST_EMPTY (a_aempty), .COUNT (a_count),
        .OVERFLOW (a_ovf), .UNDERFLOW (a_unf)
    );

    efx_fifo_sync #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (4),
        .OUTPUT_REG  (1'b1),
        .WE_POLARITY (1'b0),
        .RE_POLARITY (1'b0)
    ) dut_b (
        .CLK (clk), .RST_N (rst_n), .WDATA (b_wdata), .WE (b_we), .RE (b_re),
        .RDATA (b_rdata), .RVALID (b_rvalid), .FULL (b_full), .EMPTY (b_empty),
        .ALMOST_FULL (b_afull), .ALMOST_EMPTY (b_aempty), .COUNT (b_count),
        .OVERFLOW (b_ovf), .UNDERFLOW (b_unf)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a_flags(input string tag, input int cnt, input bit full, input bit empty,
                               input bit afull, input bit aempty);
        chk({tag, ".count"},  32'(a_count),  32'(cnt));
        chk({tag, ".full"},   32'(a_full),   32'(full));
        chk({tag, ".empty"},  32'(a_empty),  32'(empty));
        chk({tag, ".afull"},  32'(a_afull),  32'(afull));
        chk({tag, ".aempty"}, 32'(a_aempty), 32'(aempty));
    endtask

    task automatic chk_a_reset(input string tag);
        chk_a_flags(tag, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk({tag, ".rvalid"}, 32'(a_rvalid), 32'd0);
        chk({tag, ".rdata"},  32'(a_rdata),  32'd0);
        chk({tag, ".ovf"},    32'(a_ovf),    32'd0);
        chk({tag, ".unf"},    32'(a_unf),    32'd0);
    endtask

    initial begin
        logic [DW-1:0] exp_word;

        rst_n   = 1'b0;
        a_we    = 1'b0; a_re = 1'b0; a_wdata = '0;
        b_we    = 1'b1; b_re = 1'b1; b_wdata = '0;

        // Reset state
        step(); step();
        chk_a_reset("reset_a");
        chk("reset_b.count", 32'(b_count), 32'd0);
        chk("reset_b.empty", 32'(b_empty), 32'd1);
        chk("reset_b.rdata", 32'(b_rdata), 32'd0);
        #3 rst_n = 1'b1;

        // Four writes then four reads, one cycle read latency
        for (int i = 1; i <= 4; i++) begin
            a_wdata = DW'(i);
            a_we    = 1'b1;
            step();
            chk("wr4.count", 32'(a_count), 32'(i));
        end
        chk_a_flags("wr4.end", 4, 1'b0, 1'b0, 1'b0, 1'b0);
        a_we = 1'b0;
        a_re = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("rd4.rdata",  32'(a_rdata),  32'(i));
            chk("rd4.rvalid", 32'(a_rvalid), 32'd1);
        end
        a_re = 1'b0;
        step();
        chk("rd4.idle_rvalid", 32'(a_rvalid), 32'd0);
        chk("rd4.hold_rdata",  32'(a_rdata),  32'd4);
        chk_a_flags("rd4.end", 0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Fill to full; almost-full from 254, almost-empty up to 2
        a_we = 1'b1;
        for (int i = 0; i < 256; i++) begin
            a_wdata = DW'(32'hA0000 + i);
            step();
            chk("fill.count",  32'(a_count),  32'(i + 1));
            chk("fill.afull",  32'(a_afull),  32'((i + 1) >= 254));
            chk("fill.full",   32'(a_full),   32'((i + 1) == 256));
            chk("fill.aempty", 32'(a_aempty), 32'((i + 1) <= 2));
        end
        a_wdata = 20'hFFFFF;
        step();
        chk_a_flags("ovf", 256, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("ovf.flag", 32'(a_ovf), 32'd1);

        // Read and write together while full: read wins, write dropped
        a_wdata = 20'h55555;
        a_re    = 1'b1;
        step();
        chk_a_flags("full_rw", 255, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("full_rw.rdata",  32'(a_rdata),  32'hA0000);
        chk("full_rw.rvalid", 32'(a_rvalid), 32'd1);
        a_we = 1'b0;
        for (int i = 1; i < 256; i++) begin
            step();
            chk("drain.rdata", 32'(a_rdata), 32'hA0000 + 32'(i));
        end
        chk_a_flags("drain.end", 0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Read and write together while empty: write wins, no underflow
        a_we    = 1'b1;
        a_wdata = 20'h12345;
        step();
        chk_a_flags("empty_rw", 1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("empty_rw.rvalid", 32'(a_rvalid), 32'd0);
        chk("empty_rw.unf",    32'(a_unf),    32'd0);
        chk("empty_rw.rdata",  32'(a_rdata),  32'hA00FF);
        a_we = 1'b0;
        step();
        chk("empty_rw.pop",    32'(a_rdata),  32'h12345);
        chk("empty_rw.pop_v",  32'(a_rvalid), 32'd1);
        step();
        chk("unf.flag",   32'(a_unf),    32'd1);
        chk("unf.rvalid", 32'(a_rvalid), 32'd0);
        chk("unf.count",  32'(a_count),  32'd0);
        a_re = 1'b0;

        // Steady simultaneous traffic at half occupancy across three wraps
        a_we = 1'b1;
        for (int i = 0; i < 128; i++) begin
            a_wdata = DW'(i * 37 + 5);
            exp_q.push_back(a_wdata);
            step();
        end
        chk("wrap.prefill", 32'(a_count), 32'd128);
        a_re = 1'b1;
        for (int i = 0; i < 768; i++) begin
            a_wdata = DW'(32'h40000 + i * 13);
            exp_q.push_back(a_wdata);
            step();
            exp_word = exp_q.pop_front();
            chk("wrap.rdata",  32'(a_rdata),  32'(exp_word));
            chk("wrap.rvalid", 32'(a_rvalid), 32'd1);
            chk("wrap.count",  32'(a_count),  32'd128);
        end
        a_we = 1'b0;
        for (int i = 0; i < 128; i++) begin
            step();
            exp_word = exp_q.pop_front();
            chk("wrap.drain", 32'(a_rdata), 32'(exp_word));
        end
        a_re = 1'b0;
        chk_a_flags("wrap.end", 0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Output register with active-low requests: two-cycle read latency
        b_we = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            b_wdata = DW'(32'h0B000 + i);
            step();
        end
        chk("b.count3", 32'(b_count), 32'd3);
        chk("b.empty",  32'(b_empty), 32'd0);
        b_we = 1'b1;
        b_re = 1'b0;
        step();
        chk("b.lat1_rvalid", 32'(b_rvalid), 32'd0);
        chk("b.lat1_count",  32'(b_count),  32'd2);
        step();
        chk("b.rd1_rvalid", 32'(b_rvalid), 32'd1);
        chk("b.rd1_rdata",  32'(b_rdata),  32'h0B001);
        step();
        chk("b.rd2_rdata",  32'(b_rdata),  32'h0B002);
        chk("b.rd2_count",  32'(b_count),  32'd0);
        b_re = 1'b1;
        step();
        chk("b.rd3_rdata",  32'(b_rdata),  32'h0B003);
        chk("b.rd3_rvalid", 32'(b_rvalid), 32'd1);
        step();
        chk("b.idle_rvalid", 32'(b_rvalid), 32'd0);
        chk("b.hold_rdata",  32'(b_rdata),  32'h0B003);
        chk("b.unf",         32'(b_unf),    32'd0);

        // Asynchronous reset in the middle of a burst
        a_we = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            a_wdata = DW'(32'h0AAA0 + i);
            step();
        end
        a_wdata = 20'h0AAA4;
        a_re    = 1'b1;
        step();
        chk("burst.rdata", 32'(a_rdata), 32'h0AAA1);
        chk("burst.count", 32'(a_count), 32'd3);
        chk("burst.ovf",   32'(a_ovf),   32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk_a_reset("async_rst");
        a_we = 1'b0;
        a_re = 1'b0;
        step();
        #3 rst_n = 1'b1;
        a_we    = 1'b1;
        a_wdata = 20'h0C0DE;
        step();
        chk("post_rst.count", 32'(a_count), 32'd1);
        a_we = 1'b0;
        a_re = 1'b1;
        step();
        chk("post_rst.rdata",  32'(a_rdata),  32'h0C0DE);
        chk("post_rst.rvalid", 32'(a_rvalid), 32'd1);
        chk("post_rst.count",  32'(a_count),  32'd0);
        a_re = 1'b0;
        step();

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
